bcdtime_sync: RTL
=================

BCDTIME_SYNC -- requirements
Module: bcdtime_sync

Interface
REQ-001 Parameter TIMEOUT_MS, default 1500: ms ticks to wait for 1pps before aborting a load.
REQ-002 Parameter VERIFY_DLY, default 1: 1pps periods after set before the verify compare.
REQ-003 clk  input  1  system clock; all logic rising-edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 tsc_1pps  input  1  one-cycle pulse per second.
REQ-006 tsc_1ppms  input  1  one-cycle pulse per millisecond.
REQ-007 load_req  input  1  level request to load load_time; held until load_ack.
REQ-008 load_time  input  time_t  requested time of day, valid while load_req high; ms digits ignored.
REQ-009 load_ack  output  1  one-cycle pulse: request accepted or rejected.
REQ-010 load_err  output  1  one-cycle pulse with load_ack when load_time is invalid.
REQ-011 cur_time  input  time_t  current value from bcdtime.
REQ-012 set  output  1  one-cycle load strobe to bcdtime.
REQ-013 set_time  output  time_t  value loaded by bcdtime on set.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 timeout  output  1  one-cycle pulse when the 1pps wait expires.
REQ-016 mismatch  output  1  sticky flag: verify compare failed; cleared by the next accepted load.

Function
REQ-017 FSM states: IDLE, CALC, WAIT_PPS, SET, VERIFY.
REQ-018 IDLE, load_req=1: validate every digit.
- Digits <=9; t_10s, t_10m <=5; hours <=23.
- Invalid: load_ack=1, load_err=1 the next cycle; stay IDLE.
- Valid: capture load_time, pulse load_ack, go to CALC.
REQ-019 load_req while busy is not acknowledged; it waits until IDLE.
REQ-020 CALC, one cycle: target = captured hh:mm:ss + 1 s, BCD carry chain s->10s->m->10m->h->10h.
- 23:59:59 wraps to 00:00:00.
- ms digits of target are 000.
- Go to WAIT_PPS.
REQ-021 WAIT_PPS: ms counter clears on entry and increments per tsc_1ppms; a tsc_1pps in the capture cycle is not used.
REQ-022 WAIT_PPS, tsc_1pps=1: set=1 and set_time=target in that same cycle; go to SET.
REQ-023 WAIT_PPS, counter reaches TIMEOUT_MS with no tsc_1pps: pulse timeout, no set; go to IDLE.
- tsc_1pps and the final ms tick in the same cycle: the tsc_1pps wins.
REQ-024 SET, one cycle: expected = target + 1 s (same carry and wrap rules); go to VERIFY.
REQ-025 VERIFY: count VERIFY_DLY tsc_1pps pulses, then in the cycle after the last one compare cur_time hh:mm:ss with expected.
- Inequality sets mismatch.
- Go to IDLE.
- If VERIFY_DLY>1, expected advances 1 s per counted pulse.
REQ-026 set_time holds its last value outside SET; set is never high on consecutive cycles.
REQ-027 load_req and tsc_1pps together in IDLE: capture, and the set aligns to the following tsc_1pps.

Reset
REQ-028 rst_n=0 at a clock edge: FSM=IDLE; load_ack, load_err, set, timeout, busy, mismatch = 0; set_time = all zero digits; counters = 0.
REQ-029 Reset in any state, including the SET cycle, abandons the operation; no set is issued after reset releases.

Configuration
REQ-030 Macro BCDTIME_SYNC_VERIFY_EN.
- Defined: SET -> VERIFY, mismatch works as specified.
- Undefined: SET -> IDLE, mismatch is constant 0, expected/VERIFY logic is absent, VERIFY_DLY is unused.

Verification
REQ-031 Load 12:34:56 valid; tsc_1pps 400 ms later -> set for one cycle on the pps cycle, set_time 12:34:57.000; with VERIFY_EN, mismatch=0 after next pps.
REQ-032 Load 23:59:59 -> set_time 00:00:00.000; load 09:59:59 -> 10:00:00.000.
REQ-033 Load t_10m=6 or hours 24 -> load_ack and load_err on the same cycle, busy stays 0, no set.
REQ-034 Valid load, tsc_1pps suppressed -> timeout pulse after 1500 tsc_1ppms, busy falls, set never asserted.
REQ-035 VERIFY_EN, cur_time forced to 00:00:00 after set -> mismatch=1 after the verify pps; next valid load clears it.
REQ-036 rst_n low for one cycle while in WAIT_PPS, then pps -> no set, all outputs at reset values, busy=0.

Source files
------------

// File: rtl/bcdtime_sync.sv
// bcdtime_sync: aligns a requested time-of-day load to the next 1pps edge and optionally verifies it.
// Ports:
//   clk, rst_n            system clock, synchronous active-low reset
//   tsc_1pps, tsc_1ppms   one-cycle second / millisecond ticks
//   load_req, load_time   level load request and requested time (ms digits ignored)
//   load_ack, load_err    one-cycle accept/reject pulse, error flag for invalid time
//   cur_time              current time from bcdtime (used for verify)
//   set, set_time         one-cycle load strobe and value to bcdtime
//   busy, timeout         not-idle flag, one-cycle pulse when 1pps wait expires
//   mismatch              sticky verify-failure flag
// Optional verify stage enabled by defining BCDTIME_SYNC_VERIFY_EN.
package bcdtime_sync_pkg;
    typedef struct packed {
        logic [3:0] h10, h1, m10, m1, s10, s1, ms100, ms10, ms1;
    } time_t;
endpackage

module bcdtime_sync
    import bcdtime_sync_pkg::*;
#(
    parameter int TIMEOUT_MS = 1500,
    parameter int VERIFY_DLY = 1
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  tsc_1pps,
    input  logic  tsc_1ppms,
    input  logic  load_req,
    input  time_t load_time,
    output logic  load_ack,
    output logic  load_err,
    input  time_t cur_time,
    output logic  set,
    output time_t set_time,
    output logic  busy,
    output logic  timeout,
    output logic  mismatch
);
    typedef enum logic [2:0] {IDLE, CALC, WAIT_PPS, SET, VERIFY} state_t;
    localparam int MW = $clog2(TIMEOUT_MS + 1);
    localparam logic [MW-1:0] MS_LAST = MW'(TIMEOUT_MS - 1);

    // Advance hh:mm:ss by one second with BCD carries; ms digits forced to zero.
    function automatic time_t inc_sec(input time_t t);
        time_t r;
        logic  c;
        logic  h_wrap;
        r      = '0;
        c      = 1'b1;
        r.s1   = (t.s1 == 4'd9) ? 4'd0 : t.s1 + 4'd1;
        c      = (t.s1 == 4'd9);
        r.s10  = c ? ((t.s10 == 4'd5) ? 4'd0 : t.s10 + 4'd1) : t.s10;
        c      = c && (t.s10 == 4'd5);
        r.m1   = c ? ((t.m1 == 4'd9) ? 4'd0 : t.m1 + 4'd1) : t.m1;
        c      = c && (t.m1 == 4'd9);
        r.m10  = c ? ((t.m10 == 4'd5) ? 4'd0 : t.m10 + 4'd1) : t.m10;
        c      = c && (t.m10 == 4'd5);
        h_wrap = (t.h10 == 4'd2) && (t.h1 == 4'd3);
        r.h1   = !c ? t.h1 : (h_wrap || t.h1 == 4'd9) ? 4'd0 : t.h1 + 4'd1;
        r.h10  = !c ? t.h10 : h_wrap ? 4'd0 : (t.h1 == 4'd9) ? t.h10 + 4'd1 : t.h10;
        return r;
    endfunction

    state_t         state, state_nx;
    time_t          tgt, set_time_q;
    logic [MW-1:0]  ms_cnt;
    logic           valid, accept, tmo_hit;

    assign valid = (load_time.s1 <= 4'd9) && (load_time.s10 <= 4'd5) &&
                   (load_time.m1 <= 4'd9) && (load_time.m10 <= 4'd5) &&
                   (load_time.h1 <= 4'd9) &&
                   ((load_time.h10 < 4'd2) || (load_time.h10 == 4'd2 && load_time.h1 <= 4'd3));
    // An outstanding ack means the requester has not yet seen it; do not re-evaluate.
    assign accept  = (state == IDLE) && load_req && !load_ack;
    // A 1pps in the same cycle as the final ms tick takes priority over the timeout.
    assign tmo_hit = (state == WAIT_PPS) && !tsc_1pps && tsc_1ppms && (ms_cnt == MS_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

`ifdef BCDTIME_SYNC_VERIFY_EN
    localparam int PW = $clog2(VERIFY_DLY + 1);
    localparam logic [PW-1:0] PPS_LAST = PW'(VERIFY_DLY - 1);
    time_t          exp_t;
    logic [PW-1:0]  pps_cnt;
    logic           cmp_pend;
    logic           pps_cnt_ev;
    logic           unused_ok;

    assign pps_cnt_ev = (state == VERIFY) && tsc_1pps && !cmp_pend;
    assign unused_ok  = ^{cur_time[11:0], exp_t[11:0]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            exp_t    <= '0;
            pps_cnt  <= '0;
            cmp_pend <= 1'b0;
            mismatch <= 1'b0;
        end else begin
            cmp_pend <= pps_cnt_ev && (pps_cnt == PPS_LAST);
            if (state == SET) begin
                exp_t   <= inc_sec(tgt);
                pps_cnt <= '0;
            end else if (pps_cnt_ev) begin
                pps_cnt <= pps_cnt + PW'(1);
                if (pps_cnt != PPS_LAST)
                    exp_t <= inc_sec(exp_t);
            end
            if (accept && valid)
                mismatch <= 1'b0;
            else if (state == VERIFY && cmp_pend && cur_time[35:12] != exp_t[35:12])
                mismatch <= 1'b1;
        end
    end
`else
    logic unused_ok;
    assign unused_ok = ^{cur_time, VERIFY_DLY};
    assign mismatch  = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:     state_nx = (accept && valid) ? CALC : IDLE;
            CALC:     state_nx = WAIT_PPS;
            WAIT_PPS: state_nx = tsc_1pps ? SET : tmo_hit ? IDLE : WAIT_PPS;
`ifdef BCDTIME_SYNC_VERIFY_EN
            SET:      state_nx = VERIFY;
            VERIFY:   state_nx = cmp_pend ? IDLE : VERIFY;
`else
            SET:      state_nx = IDLE;
            VERIFY:   state_nx = IDLE;
`endif
            default:  state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != IDLE);
        set      = rst_n && (state == WAIT_PPS) && tsc_1pps;
        timeout  = rst_n && tmo_hit;
        set_time = set ? tgt : set_time_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tgt        <= '0;
            set_time_q <= '0;
            ms_cnt     <= '0;
            load_ack   <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            load_ack <= accept;
            load_err <= accept && !valid;
            if (accept && valid)
                tgt <= load_time;
            if (state == CALC) begin
                tgt    <= inc_sec(tgt);
                ms_cnt <= '0;
            end else if (state == WAIT_PPS && tsc_1ppms) begin
                ms_cnt <= ms_cnt + MW'(1);
            end
            if (set)
                set_time_q <= tgt;
        end
    end
endmodule
